// File: rtl/half_adder_bist.sv
// Built-in self test for an external half adder: walks all four input vectors,
// waits SETTLE_CYCLES clocks for each, then checks sum/carry against a^b / a&b.
// Latency: SETTLE_CYCLES+1 clocks per vector, done 4*(SETTLE_CYCLES+1) clocks after start.
// Backpressure: none; start is ignored while busy, results held in DONE until restart.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   start, continuous    run request; loop the vector set instead of stopping
//   dut_a, dut_b         registered stimulus to the half adder under test
//   dut_sum, dut_carry   half adder responses
//   busy, done, pass     run status
//   err_count            saturating mismatch count (ERR_W bits)
//   fail_valid, fail_vec first failing vector {b,a} and its valid flag
module half_adder_bist #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Counter is loaded with SETTLE_CYCLES-1 so that the SETTLE phase lasts
  // exactly SETTLE_CYCLES clocks (the zero count is spent in SETTLE too).
  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [1:0]       fail_vec_q, fail_vec_d;
  logic             mismatch;

  // vec[0] drives a, vec[1] drives b, so counting 0..3 applies ab = 00,10,01,11.
  assign mismatch = (dut_sum   != (vec_q[0] ^ vec_q[1])) ||
                    (dut_carry != (vec_q[0] & vec_q[1]));

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = 2'b00;
          vec_d        = 2'b00;
          cnt_d        = SETTLE_LOAD;
          state_d      = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_ONE;
          end
          // Only the first failure of a run is captured.
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
          end
        end

        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end else if (continuous) begin
          // Looping keeps the accumulated error count and first-fail capture.
          vec_d   = 2'd0;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_q        <= 2'b00;
      cnt_q        <= 8'd0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign dut_a      = vec_q[0];
  assign dut_b      = vec_q[1];
  assign busy       = (state_q == SETTLE) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign pass       = (state_q == DONE) && (err_q == '0);
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule
